// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - divide sequencer and architectural HI/LO register owner
//
// Accepts DIV / MTHI / MTLO commands when idle. For a DIV it registers the
// operands and issues a one-cycle start pulse to the external divider. It then
// waits for completion, divide-by-zero or a watchdog expiry, and commits the
// divider result into HI/LO only on a clean completion.
//
// Ports:
//   clk_i, reset_i          clock (rising edge), async active-high reset
//   cmd_valid_i/cmd_op_i    command strobe and opcode (00 DIV, 01 MTHI, 10 MTLO, 11 none)
//   cmd_a_i/cmd_b_i         dividend or MT source / divisor
//   cmd_ready_o             command can be accepted this cycle (!busy)
//   flush_i                 synchronous abort of an in-flight DIV
//   busy_o                  pipeline stall request
//   div_start_o             one-cycle start pulse to the divider
//   div_a_o/div_b_o         registered divider operands
//   div_stop_i/div_zero_i   divider completion / divide-by-zero flags
//   div_hi_i/div_lo_i       divider remainder / quotient
//   hi_out_o/lo_out_o       architectural HI / LO
//   done_o                  pulse: DIV result committed
//   div_zero_exc_o          pulse: DIV ended with divisor zero
//   timeout_err_o           pulse: divider watchdog expired
module muldiv_ctrl #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_a_i,
  input  logic [31:0] cmd_b_i,
  output logic        cmd_ready_o,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        div_start_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  input  logic        div_stop_i,
  input  logic        div_zero_i,
  input  logic [31:0] div_hi_i,
  input  logic [31:0] div_lo_i,
  output logic [31:0] hi_out_o,
  output logic [31:0] lo_out_o,
  output logic        done_o,
  output logic        div_zero_exc_o,
  output logic        timeout_err_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_e;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_MTHI = 2'b01;
  localparam logic [1:0] OP_MTLO = 2'b10;

  // Last WAIT count value before the watchdog fires; WAIT lasts TIMEOUT cycles.
  localparam logic [5:0] LAST_CNT = 6'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [5:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] div_a_q, div_a_d;
  logic [31:0] div_b_q, div_b_d;
  logic        done_q, done_d;
  logic        zexc_q, zexc_d;
  logic        tmo_q, tmo_d;

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_a_q    <= '0;
      div_b_q    <= '0;
      done_q     <= 1'b0;
      zexc_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      done_q     <= done_d;
      zexc_q     <= zexc_d;
      tmo_q      <= tmo_d;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    done_d     = 1'b0;
    zexc_d     = 1'b0;
    tmo_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Divider outputs are deliberately ignored here so late completions
        // from an aborted DIV never reach HI/LO.
        if (cmd_valid_i) begin
          unique case (cmd_op_i)
            OP_DIV: begin
              div_a_d = cmd_a_i;
              div_b_d = cmd_b_i;
              state_d = S_LAUNCH;
            end
            OP_MTHI: hi_d = cmd_a_i;
            OP_MTLO: lo_d = cmd_a_i;
            default: ;
          endcase
        end
      end
      S_LAUNCH: begin
        // The start pulse has already gone out this cycle; a flush only
        // prevents us from waiting for its result.
        wait_cnt_d = '0;
        state_d    = flush_i ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 6'd1;
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (div_stop_i && div_zero_i) begin
          zexc_d  = 1'b1;
          state_d = S_IDLE;
        end else if (div_stop_i) begin
          hi_d    = div_hi_i;
          lo_d    = div_lo_i;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (wait_cnt_q == LAST_CNT) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs. div_start is decoded from state so an async reset drops it at once.
  always_comb begin
    busy_o         = (state_q != S_IDLE);
    cmd_ready_o    = (state_q == S_IDLE);
    div_start_o    = (state_q == S_LAUNCH);
    div_a_o        = div_a_q;
    div_b_o        = div_b_q;
    hi_out_o       = hi_q;
    lo_out_o       = lo_q;
    done_o         = done_q;
    div_zero_exc_o = zexc_q;
    timeout_err_o  = tmo_q;
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl with a behavioural divider stub
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic        flush = 1'b0;
  logic        div_stop, div_zero;
  logic [31:0] div_hi, div_lo;
  logic        cmd_ready, busy, div_start, done, div_zero_exc, timeout_err;
  logic [31:0] div_a, div_b, hi_out, lo_out;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int pulse_cnt = 0;
  bit hang = 1'b0;

  localparam int LAT = 32;

  typedef struct {
    logic [2:0]  kind;   // onehot {timeout, zero, done}
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [2:0] K_DONE = 3'b001;
  localparam logic [2:0] K_ZERO = 3'b010;
  localparam logic [2:0] K_TMO  = 3'b100;

  always #5 clk = ~clk;

  muldiv_ctrl #(.TIMEOUT(40)) dut (
    .clk_i(clk), .reset_i(reset),
    .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .cmd_ready_o(cmd_ready), .flush_i(flush), .busy_o(busy),
    .div_start_o(div_start), .div_a_o(div_a), .div_b_o(div_b),
    .div_stop_i(div_stop), .div_zero_i(div_zero), .div_hi_i(div_hi), .div_lo_i(div_lo),
    .hi_out_o(hi_out), .lo_out_o(lo_out),
    .done_o(done), .div_zero_exc_o(div_zero_exc), .timeout_err_o(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Divider stub: zero divisor flags at once, otherwise completes LAT cycles later.
  int          lat_cnt;
  logic [31:0] sa, sb;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      div_stop <= 1'b0; div_zero <= 1'b0; div_hi <= '0; div_lo <= '0;
      lat_cnt <= 0; sa <= '0; sb <= '0;
    end else begin
      div_stop <= 1'b0;
      div_zero <= 1'b0;
      if (div_start) begin
        sa <= div_a; sb <= div_b;
        if (div_b == 0) begin
          div_stop <= 1'b1; div_zero <= 1'b1; lat_cnt <= 0;
        end else begin
          lat_cnt <= LAT;
        end
      end else if (lat_cnt > 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1 && !hang) begin
          div_stop <= 1'b1;
          div_lo   <= $signed(sa) / $signed(sb);
          div_hi   <= $signed(sa) % $signed(sb);
        end
      end
    end
  end

  // Monitor: every result pulse pops one expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (div_start) start_cnt++;
      if (done || div_zero_exc || timeout_err) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {29'd0, timeout_err, div_zero_exc, done}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_kind", {29'd0, timeout_err, div_zero_exc, done}, {29'd0, e.kind});
          check("pulse_hi", hi_out, e.hi);
          check("pulse_lo", lo_out, e.lo);
        end
      end
    end
  end

  task automatic push(input logic [2:0] k, input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.kind = k; e.hi = h; e.lo = l;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("issue_wait_expired", 32'd1, 32'd0);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin @(negedge clk); n++; end
    if (n >= bound) check("busy_wait_expired", 32'd1, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hi"}, hi_out, 32'd0);
    check({tag, "_lo"}, lo_out, 32'd0);
    check({tag, "_diva"}, div_a, 32'd0);
    check({tag, "_divb"}, div_b, 32'd0);
    check({tag, "_ctl"}, {26'd0, div_start, done, div_zero_exc, timeout_err, busy, cmd_ready},
          32'd1);
  endtask

  initial begin
    int n;
    int p0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // DIV 100/7
    push(K_DONE, 32'd2, 32'd14);
    issue(2'b00, 32'd100, 32'd7);
    check("launch_start", {30'd0, div_start, busy}, 32'd3);
    check("launch_ops_a", div_a, 32'd100);
    check("launch_ops_b", div_b, 32'd7);
    @(negedge clk);
    check("wait_start_low", {30'd0, div_start, busy}, 32'd1);
    wait_idle(100);
    @(negedge clk);
    check("start_count", start_cnt, 32'd1);
    check("done_count", pulse_cnt, 32'd1);

    // DIV -7/2, then MTHI
    push(K_DONE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(2'b00, 32'hFFFF_FFF9, 32'd2);
    wait_idle(100);
    @(negedge clk);
    issue(2'b01, 32'h0000_1234, 32'd0);
    check("mthi_hi", hi_out, 32'h0000_1234);
    check("mthi_lo", lo_out, 32'hFFFF_FFFD);

    // Reserved op has no effect
    issue(2'b11, 32'hDEAD_BEEF, 32'd1);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    check("rsvd_hi", hi_out, 32'h0000_1234);

    // Preload HI/LO, DIV 9/0
    issue(2'b01, 32'd5, 32'd0);
    issue(2'b10, 32'd6, 32'd0);
    p0 = pulse_cnt;
    push(K_ZERO, 32'd5, 32'd6);
    issue(2'b00, 32'd9, 32'd0);
    @(negedge clk);
    check("zero_busy_wait", {30'd0, busy, div_zero_exc}, 32'd2);
    @(negedge clk);
    check("zero_exc_pulse", {29'd0, busy, div_zero_exc, done}, 32'd2);
    @(negedge clk);
    check("zero_exc_once", {30'd0, div_zero_exc, done}, 32'd0);
    check("zero_pulses", pulse_cnt - p0, 32'd1);

    // Hung divider -> watchdog
    hang = 1'b1;
    push(K_TMO, 32'd5, 32'd6);
    issue(2'b00, 32'd50, 32'd5);
    n = 0;
    while (!timeout_err && n < 100) begin @(negedge clk); n++; end
    check("timeout_latency", n, 32'd41);
    check("timeout_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    check("timeout_once", {31'd0, timeout_err}, 32'd0);
    hang = 1'b0;
    repeat (3) @(negedge clk);

    // DIV 1000/3 flushed; held MTLO only accepted once idle
    p0 = pulse_cnt;
    issue(2'b00, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 32'd7; cmd_b = '0;
    repeat (5) @(negedge clk);
    check("held_mtlo_lo", lo_out, 32'd6);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", {31'd0, busy}, 32'd0);
    check("held_mtlo_not_taken", lo_out, 32'd6);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mtlo_after", lo_out, 32'd7);
    repeat (30) @(negedge clk);
    check("flush_no_pulse", pulse_cnt - p0, 32'd0);
    check("flush_hi_kept", hi_out, 32'd5);
    check("flush_lo_kept", lo_out, 32'd7);

    // Async reset mid-WAIT
    issue(2'b00, 32'd500, 32'd5);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals("async_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push(K_DONE, 32'd0, 32'd5);
    issue(2'b00, 32'd20, 32'd4);
    wait_idle(100);
    @(negedge clk);
    check("final_hi", hi_out, 32'd0);
    check("final_lo", lo_out, 32'd5);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer and HI/LO register owner for the multi-cycle signed divider. It accepts DIV, MTHI and MTLO commands from the main control unit and issues a one-cycle start pulse with registered operands to the divider. It then waits for completion, commits the result into the architectural HI/LO registers and reports divide-by-zero or a hung divider. `busy` stalls the pipeline; MFHI/MFLO read `hi_out`/`lo_out` directly.

## Interface
- `TIMEOUT`, default 40: max cycles spent in WAIT before declaring the divider hung.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `cmd_valid`  in  1  command present this cycle.
- `cmd_op`  in  2  00=DIV, 01=MTHI, 10=MTLO, 11=reserved (accepted, no effect).
- `cmd_a`  in  32  dividend for DIV, or the source value for MTHI/MTLO.
- `cmd_b`  in  32  divisor; DIV only.
- `cmd_ready`  out  1  combinational `!busy`.
- `flush`  in  1  synchronous abort of an in-flight DIV.
- `busy`  out  1  state != IDLE; pipeline stall request.
- `div_start`  out  1  one-cycle pulse to the divider's start input.
- `div_a`, `div_b`  out  32  registered operands to the divider.
- `div_stop`  in  1  divider completion flag.
- `div_zero`  in  1  divider divide-by-zero flag.
- `div_hi`, `div_lo`  in  32  divider remainder and quotient.
- `hi_out`, `lo_out`  out  32  architectural HI and LO.
- `done`  out  1  one-cycle pulse: DIV result committed.
- `div_zero_exc`  out  1  one-cycle pulse: DIV aborted because the divisor was 0.
- `timeout_err`  out  1  one-cycle pulse: watchdog expired.

## Operation
- States: IDLE, LAUNCH, WAIT. Registered `wait_cnt` is 6 bits wide.
- IDLE. A command is accepted on a rising edge where `cmd_valid && cmd_ready`.
  - DIV: latch `div_a<=cmd_a`, `div_b<=cmd_b`; go to LAUNCH.
  - MTHI: `hi_out<=cmd_a`; stay in IDLE.
  - MTLO: `lo_out<=cmd_a`; stay in IDLE.
  - Reserved op: no state change.
- LAUNCH. `div_start=1` for exactly this cycle. Clear `wait_cnt`; go to WAIT.
- WAIT. Increment `wait_cnt` every cycle. On each edge, priority high to low:
  1. `flush`: go to IDLE. HI/LO unchanged, no pulses.
  2. `div_stop && div_zero`: pulse `div_zero_exc`. HI/LO unchanged. Go to IDLE.
  3. `div_stop`: `hi_out<=div_hi`, `lo_out<=div_lo`, pulse `done`. Go to IDLE.
  4. `wait_cnt==TIMEOUT-1`: pulse `timeout_err`. HI/LO unchanged. Go to IDLE.
- `flush` in IDLE or LAUNCH:
  - In IDLE it has no effect.
  - In LAUNCH the start pulse still issues, and the FSM returns to IDLE instead of entering WAIT.
- Once back in IDLE, the controller ignores `div_stop`/`div_zero`/`div_hi`/`div_lo`. Stale or late completions from an aborted DIV are never committed.
- `cmd_valid` while busy: not accepted, no side effect. The requester holds the command.
- All arithmetic (sign handling, remainder sign) is the divider's job. The controller copies 32-bit values unmodified.

## Timing
- Reset values: `hi_out=0`, `lo_out=0`, `div_a=0`, `div_b=0`, `div_start=0`, `done=0`, `div_zero_exc=0`, `timeout_err=0`, `busy=0`, `cmd_ready=1`, state IDLE, `wait_cnt=0`.
- DIV accepted at edge E0:
  - LAUNCH occupies cycle E0..E1, with `div_start` high in that cycle.
  - The divider samples start at E1.
  - WAIT begins after E1.
- Divide-by-zero: the divider raises `div_stop`/`div_zero` at E1. `div_zero_exc` pulses in the cycle after E2. Total busy time is 2 cycles.
- Normal DIV: completes about 32 cycles after E1. `hi_out`/`lo_out` update on the same edge where `done` is registered high. `done` and the error pulses last exactly one cycle.
- `busy` falls on the completion edge. A new command is accepted on the following edge at the earliest, so there is no back-to-back accept in the completion cycle.
- Asynchronous `reset` mid-DIV:
  - All outputs go to their reset values immediately.
  - `div_start` deasserts.
  - HI/LO are cleared.

## Test plan
- Reset, then DIV 100/7 -> one `div_start` pulse; `busy` high until commit; `done` pulse; `hi_out=2`, `lo_out=14`.
- DIV -7/2 -> `lo_out=0xFFFFFFFD`, `hi_out=0xFFFFFFFF`. Then MTHI 0x1234 -> `hi_out=0x00001234`, `lo_out` unchanged.
- Preload HI=5, LO=6; DIV 9/0 -> `div_zero_exc` pulse 2 cycles after accept; no `done`; HI=5, LO=6 retained.
- Stub divider never asserts `div_stop`, TIMEOUT=40 -> `timeout_err` pulse after 40 WAIT cycles; HI/LO unchanged; `cmd_ready` returns to 1.
- DIV 1000/3, assert `flush` 10 cycles into WAIT -> IDLE next edge, no `done`, and the later `div_stop` is ignored. MTLO 7 issued while busy is not accepted; reissued after `busy` falls, it gives `lo_out=7`.
- Async `reset` pulse mid-WAIT -> all outputs are 0 at once (`cmd_ready=1`); a subsequent DIV 20/4 gives HI=0, LO=5.
